trap_ctrl: RTL and testbench



---
 rtl/trap_pkg.sv | 36 +++
 rtl/trap_csr_file.sv | 152 +++++++++++++++
 rtl/trap_ctrl.sv | 141 ++++++++++++++
 tb/tb_trap_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// FSM states, CSR addresses, cause codes, CSR op encodings, mstatus bits.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP,
        ST_RET,
        ST_DRAIN
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
    localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;

    localparam logic [1:0] CSR_OP_READ  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIE_MTIE_BIT     = 7;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR registers with read mux and write/set/clear update.
// mie/mip contents exist only when TRAP_CTRL_IRQ_EN is defined.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [11:0] addr_i,
    input  logic        wr_en_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] wdata_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_tmr_i,
    output logic [31:0] rdata_o,
    output logic        addr_ok_o,
    output logic        mstatus_mie_o,
    output logic        meie_o,
    output logic        mtie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic [31:0] wval;

`ifndef TRAP_CTRL_IRQ_EN
    logic unused_irq;
    assign unused_irq = irq_ext_i ^ irq_tmr_i;
`endif

    // Read mux: returns the current (old) value of the addressed CSR.
    always_comb begin
        rdata_o   = '0;
        addr_ok_o = 1'b1;
        unique case (addr_i)
            CSR_MSTATUS: begin
                rdata_o[12:11]           = 2'b11;
                rdata_o[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                rdata_o[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE: begin
`ifdef TRAP_CTRL_IRQ_EN
                rdata_o[MIE_MEIE_BIT] = meie_q;
                rdata_o[MIE_MTIE_BIT] = mtie_q;
`endif
            end
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE:   rdata_o = mcause_q;
            CSR_MIP: begin
`ifdef TRAP_CTRL_IRQ_EN
                rdata_o[MIE_MEIE_BIT] = irq_ext_i;
                rdata_o[MIE_MTIE_BIT] = irq_tmr_i;
`endif
            end
            default: addr_ok_o = 1'b0;
        endcase
    end

    // Operand merge for write, set and clear.
    always_comb begin
        unique case (op_i)
            CSR_OP_WRITE: wval = wdata_i;
            CSR_OP_SET:   wval = rdata_o | wdata_i;
            CSR_OP_CLEAR: wval = rdata_o & ~wdata_i;
            default:      wval = rdata_o;
        endcase
    end

    // Next-state: trap entry, then mret, then software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        meie_d         = meie_q;
        mtie_d         = mtie_q;
        if (trap_i) begin
            mepc_d         = {trap_pc_i[31:2], 2'b00};
            mcause_d       = trap_cause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en_i) begin
            unique case (addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: begin
`ifdef TRAP_CTRL_IRQ_EN
                    meie_d = wval[MIE_MEIE_BIT];
                    mtie_d = wval[MIE_MTIE_BIT];
`endif
                end
                CSR_MTVEC:    mtvec_d    = {wval[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wval;
                default: ;
            endcase
        end
    end

    // CSR state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtvec_q        <= {MTVEC_RST[31:2], 2'b00};
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            meie_q         <= 1'b0;
            mtie_q         <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            meie_q         <= meie_d;
            mtie_q         <= mtie_d;
        end
    end

    assign mstatus_mie_o = mstatus_mie_q;
    assign meie_o        = meie_q;
    assign mtie_o        = mtie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: event priority, redirect FSM, CSR file.
// Define TRAP_CTRL_IRQ_EN to enable the interrupt path with mie/mip.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
    parameter int          DRAIN_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic [31:0] pc_d2_i,
    input  logic        illegal_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_tmr_i,
    input  logic        csr_en_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_bad_o,
    output logic        exception_o,
    output logic        ret_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        flush_o
);

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);

    trap_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        exception_q, exception_d;
    logic        ret_q, ret_d;
    logic        flush_q, flush_d;

    logic        sample, exc_req, trap_take, mret_take, csr_wr;
    logic        irq_ext_take, irq_tmr_take;
    logic [31:0] cause;
    logic        addr_ok, mstatus_mie, meie, mtie;

`ifdef TRAP_CTRL_IRQ_EN
    assign irq_ext_take = mstatus_mie & meie & irq_ext_i;
    assign irq_tmr_take = mstatus_mie & mtie & irq_tmr_i;
`else
    logic unused_irq;
    assign unused_irq   = ^{irq_ext_i, irq_tmr_i, mstatus_mie, meie, mtie};
    assign irq_ext_take = 1'b0;
    assign irq_tmr_take = 1'b0;
`endif

    // Event detection and priority encode of the trap cause.
    always_comb begin
        sample    = (state_q == ST_RUN) && !stall_i;
        exc_req   = illegal_i | ebreak_i | ecall_i;
        trap_take = sample & (exc_req |
                    (!mret_i & (irq_ext_take | irq_tmr_take)));
        mret_take = sample & !exc_req & mret_i;
        csr_wr    = sample & csr_en_i & (csr_op_i != CSR_OP_READ) &
                    !trap_take & !mret_take;
        if (illegal_i)         cause = CAUSE_ILLEGAL;
        else if (ebreak_i)     cause = CAUSE_EBREAK;
        else if (ecall_i)      cause = CAUSE_ECALL;
        else if (irq_ext_take) cause = CAUSE_IRQ_EXT;
        else                   cause = CAUSE_IRQ_TMR;
    end

    // Redirect FSM next-state; outputs derive from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (trap_take)      state_d = ST_TRAP;
                else if (mret_take) state_d = ST_RET;
            end
            ST_TRAP, ST_RET: begin
                state_d = ST_DRAIN;
                cnt_d   = DRAIN_LAST;
            end
            ST_DRAIN: begin
                if (cnt_q == 2'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = ST_RUN;
        endcase
        exception_d = (state_d == ST_TRAP);
        ret_d       = (state_d == ST_RET);
        flush_d     = (state_d != ST_RUN);
    end

    // FSM state and registered redirect outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            exception_q <= 1'b0;
            ret_q       <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exception_q <= exception_d;
            ret_q       <= ret_d;
            flush_q     <= flush_d;
        end
    end

    trap_csr_file #(
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .addr_i        (csr_addr_i),
        .wr_en_i       (csr_wr),
        .op_i          (csr_op_i),
        .wdata_i       (csr_wdata_i),
        .trap_i        (trap_take),
        .trap_pc_i     (pc_d2_i),
        .trap_cause_i  (cause),
        .mret_i        (mret_take),
        .irq_ext_i     (irq_ext_i),
        .irq_tmr_i     (irq_tmr_i),
        .rdata_o       (csr_rdata_o),
        .addr_ok_o     (addr_ok),
        .mstatus_mie_o (mstatus_mie),
        .meie_o        (meie),
        .mtie_o        (mtie),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o)
    );

    assign csr_bad_o   = csr_en_i & ~addr_ok;
    assign exception_o = exception_q;
    assign ret_o       = ret_q;
    assign flush_o     = flush_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl.
// Outputs are sampled 1ns after the rising edge.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc;
    logic        illegal, ecall, ebreak, mret;
    logic        irq_ext, irq_tmr;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_bad, exception, ret, flush;
    logic [31:0] mtvec, mepc;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .stall_i     (stall),
        .pc_d2_i     (pc),
        .illegal_i   (illegal),
        .ecall_i     (ecall),
        .ebreak_i    (ebreak),
        .mret_i      (mret),
        .irq_ext_i   (irq_ext),
        .irq_tmr_i   (irq_tmr),
        .csr_en_i    (csr_en),
        .csr_op_i    (csr_op),
        .csr_addr_i  (csr_addr),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .csr_bad_o   (csr_bad),
        .exception_o (exception),
        .ret_o       (ret),
        .mtvec_o     (mtvec),
        .mepc_o      (mepc),
        .flush_o     (flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_en   = 1'b1;
        csr_op   = 2'b00;
        csr_addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] d);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_en    = 1'b0;
        csr_op    = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; pc = 0;
        illegal = 0; ecall = 0; ebreak = 0; mret = 0;
        irq_ext = 0; irq_tmr = 0;
        csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (exception !== 1'b0) $display("FAIL rst_exc got %b want 0", exception);
        else n_pass++;
        n_chk++;
        if (mtvec !== 32'h100) $display("FAIL rst_mtvec got %h want 00000100", mtvec);
        else n_pass++;
        n_chk++;
        if (flush !== 1'b0 || ret !== 1'b0) $display("FAIL rst_flush got %b%b want 00", flush, ret);
        else n_pass++;
        rd(12'h300);
        n_chk++;
        if (csr_rdata !== 32'h1800) $display("FAIL rst_mstatus got %h want 00001800", csr_rdata);
        else n_pass++;
        csr_en = 0;
    endtask

    task automatic test_ecall();
        wr(2'b01, 12'h300, 32'h88);
        rd(12'h300);
        n_chk++;
        if (csr_rdata !== 32'h1888) $display("FAIL wr_mstatus got %h want 00001888", csr_rdata);
        else n_pass++;
        csr_en = 0;
        ecall = 1; pc = 32'h40;
        tick();
        ecall = 0;
        n_chk++;
        if (exception !== 1'b1 || mepc !== 32'h40)
            $display("FAIL ecall_redirect got exc=%b mepc=%h want exc=1 mepc=00000040", exception, mepc);
        else n_pass++;
        rd(12'h342);
        n_chk++;
        if (csr_rdata !== 32'd11) $display("FAIL ecall_mcause got %h want 0000000b", csr_rdata);
        else n_pass++;
        rd(12'h300);
        n_chk++;
        if (csr_rdata !== 32'h1880) $display("FAIL ecall_mstatus got %h want 00001880", csr_rdata);
        else n_pass++;
        csr_en = 0;
        n_chk++;
        if (flush !== 1'b1) $display("FAIL flush_c1 got %b want 1", flush);
        else n_pass++;
        tick();
        n_chk++;
        if (flush !== 1'b1 || exception !== 1'b0)
            $display("FAIL flush_c2 got flush=%b exc=%b want flush=1 exc=0", flush, exception);
        else n_pass++;
        tick();
        n_chk++;
        if (flush !== 1'b1) $display("FAIL flush_c3 got %b want 1", flush);
        else n_pass++;
        tick();
        n_chk++;
        if (flush !== 1'b0) $display("FAIL flush_end got %b want 0", flush);
        else n_pass++;
    endtask

    task automatic test_mret();
        mret = 1;
        tick();
        mret = 0;
        n_chk++;
        if (ret !== 1'b1 || mepc !== 32'h40 || exception !== 1'b0)
            $display("FAIL mret_redirect got ret=%b mepc=%h exc=%b want ret=1 mepc=00000040 exc=0", ret, mepc, exception);
        else n_pass++;
        rd(12'h300);
        n_chk++;
        if (csr_rdata !== 32'h1888) $display("FAIL mret_mstatus got %h want 00001888", csr_rdata);
        else n_pass++;
        csr_en = 0;
        tick(); tick(); tick();
        n_chk++;
        if (flush !== 1'b0 || ret !== 1'b0) $display("FAIL mret_drain got flush=%b ret=%b want 0 0", flush, ret);
        else n_pass++;
    endtask

    task automatic test_priority();
        illegal = 1; ecall = 1; pc = 32'h1F;
        csr_en = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
        tick();
        illegal = 0; ecall = 0; csr_en = 0; csr_op = 0;
        n_chk++;
        if (exception !== 1'b1 || mepc !== 32'h1C)
            $display("FAIL illegal_redirect got exc=%b mepc=%h want exc=1 mepc=0000001c", exception, mepc);
        else n_pass++;
        rd(12'h342);
        n_chk++;
        if (csr_rdata !== 32'd2) $display("FAIL illegal_mcause got %h want 00000002", csr_rdata);
        else n_pass++;
        rd(12'h340);
        n_chk++;
        if (csr_rdata !== 32'h0) $display("FAIL trap_drops_write got %h want 00000000", csr_rdata);
        else n_pass++;
        csr_en = 0;
        ecall = 1;
        tick();
        n_chk++;
        if (exception !== 1'b0) $display("FAIL ignore_in_drain got %b want 0", exception);
        else n_pass++;
        ecall = 0;
        tick(); tick();
        ebreak = 1; ecall = 1; mret = 1; pc = 32'h20;
        tick();
        ebreak = 0; ecall = 0; mret = 0;
        rd(12'h342);
        n_chk++;
        if (csr_rdata !== 32'd3 || exception !== 1'b1 || ret !== 1'b0)
            $display("FAIL ebreak_prio got cause=%h exc=%b ret=%b want 00000003 1 0", csr_rdata, exception, ret);
        else n_pass++;
        csr_en = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_csr_ops();
        wr(2'b01, 12'h340, 32'hA5A5_0000);
        wr(2'b10, 12'h340, 32'h0000_00FF);
        wr(2'b11, 12'h340, 32'hA000_000F);
        rd(12'h340);
        n_chk++;
        if (csr_rdata !== 32'h05A5_00F0) $display("FAIL mscratch_ops got %h want 05a500f0", csr_rdata);
        else n_pass++;
        wr(2'b01, 12'h305, 32'h0000_0203);
        n_chk++;
        if (mtvec !== 32'h200) $display("FAIL mtvec_wr got %h want 00000200", mtvec);
        else n_pass++;
        wr(2'b01, 12'h341, 32'h0000_1237);
        n_chk++;
        if (mepc !== 32'h1234) $display("FAIL mepc_wr got %h want 00001234", mepc);
        else n_pass++;
        wr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd(12'h300);
        n_chk++;
        if (csr_rdata !== 32'h1888) $display("FAIL mstatus_mask got %h want 00001888", csr_rdata);
        else n_pass++;
        rd(12'h7C0);
        n_chk++;
        if (csr_bad !== 1'b1 || csr_rdata !== 32'h0)
            $display("FAIL unimpl got bad=%b rdata=%h want 1 00000000", csr_bad, csr_rdata);
        else n_pass++;
        rd(12'h344);
        n_chk++;
        if (csr_bad !== 1'b0) $display("FAIL mip_impl got bad=%b want 0", csr_bad);
        else n_pass++;
        csr_en = 0;
    endtask

    task automatic test_irq();
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd(12'h304);
`ifdef TRAP_CTRL_IRQ_EN
        n_chk++;
        if (csr_rdata !== 32'h880) $display("FAIL mie_mask got %h want 00000880", csr_rdata);
        else n_pass++;
        csr_en = 0;
        irq_ext = 1; pc = 32'h300;
        tick();
        rd(12'h342);
        n_chk++;
        if (exception !== 1'b1 || csr_rdata !== 32'h8000_000B)
            $display("FAIL irq_ext got exc=%b cause=%h want 1 8000000b", exception, csr_rdata);
        else n_pass++;
        csr_en = 0;
        tick(); tick(); tick(); tick();
        n_chk++;
        if (exception !== 1'b0) $display("FAIL irq_mie0 got %b want 0", exception);
        else n_pass++;
        rd(12'h344);
        n_chk++;
        if (csr_rdata !== 32'h800) $display("FAIL mip_read got %h want 00000800", csr_rdata);
        else n_pass++;
        csr_en = 0;
        irq_ext = 0;
        wr(2'b10, 12'h300, 32'h8);
        irq_tmr = 1;
        tick();
        irq_tmr = 0;
        rd(12'h342);
        n_chk++;
        if (exception !== 1'b1 || csr_rdata !== 32'h8000_0007)
            $display("FAIL irq_tmr got exc=%b cause=%h want 1 80000007", exception, csr_rdata);
        else n_pass++;
        csr_en = 0;
        tick(); tick(); tick();
`else
        n_chk++;
        if (csr_rdata !== 32'h0 || csr_bad !== 1'b0)
            $display("FAIL mie_off got %h bad=%b want 00000000 0", csr_rdata, csr_bad);
        else n_pass++;
        csr_en = 0;
        irq_ext = 1; irq_tmr = 1;
        tick();
        n_chk++;
        if (exception !== 1'b0) $display("FAIL irq_off_c1 got %b want 0", exception);
        else n_pass++;
        tick();
        n_chk++;
        if (exception !== 1'b0 || flush !== 1'b0)
            $display("FAIL irq_off_c2 got exc=%b flush=%b want 0 0", exception, flush);
        else n_pass++;
        rd(12'h344);
        n_chk++;
        if (csr_rdata !== 32'h0 || csr_bad !== 1'b0)
            $display("FAIL mip_off got %h bad=%b want 00000000 0", csr_rdata, csr_bad);
        else n_pass++;
        csr_en = 0;
        irq_ext = 0; irq_tmr = 0;
`endif
    endtask

    task automatic test_stall_reset();
        ecall = 1; stall = 1; pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (exception !== 1'b0 || flush !== 1'b0)
                $display("FAIL stall_hold%0d got exc=%b flush=%b want 0 0", i, exception, flush);
            else n_pass++;
        end
        stall = 0;
        tick();
        ecall = 0;
        n_chk++;
        if (exception !== 1'b1 || mepc !== 32'h80)
            $display("FAIL stall_release got exc=%b mepc=%h want 1 00000080", exception, mepc);
        else n_pass++;
        stall = 1;
        tick();
        n_chk++;
        if (flush !== 1'b1 || exception !== 1'b0)
            $display("FAIL stall_in_trap got flush=%b exc=%b want 1 0", flush, exception);
        else n_pass++;
        rst_n = 0;
        #1;
        n_chk++;
        if (flush !== 1'b0 || exception !== 1'b0 || ret !== 1'b0)
            $display("FAIL rst_mid_drain got flush=%b exc=%b ret=%b want 0 0 0", flush, exception, ret);
        else n_pass++;
        n_chk++;
        if (mtvec !== 32'h100 || mepc !== 32'h0)
            $display("FAIL rst_regs got mtvec=%h mepc=%h want 00000100 00000000", mtvec, mepc);
        else n_pass++;
        stall = 0;
        tick();
        rst_n = 1;
        tick();
        n_chk++;
        if (flush !== 1'b0) $display("FAIL post_rst got %b want 0", flush);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_priority();
        test_csr_ops();
        test_irq();
        test_stall_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
